// File: rtl/sdr_tx_serializer.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdr_tx_serializer: MSB-first byte serializer driving SDA on SCL falling     |
// | edges, with T-bit parity (data frame) or ACK sampling (header frame).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sdr_tx_serializer #(
  parameter int PARITY_ODD = 1
) (
  input  logic       i_sdr_ctrl_clk,
  input  logic       i_sdr_ctrl_rst,
  input  logic       i_scl_pos_edge,
  input  logic       i_scl_neg_edge,
  input  logic       i_ser_en,
  input  logic       i_ser_mode,
  input  logic       i_ser_valid,
  input  logic [7:0] i_ser_data,
  output logic       o_ser_ready,
  input  logic       i_sda,
  output logic       o_sda,
  output logic       o_sda_oe,
  output logic       o_scl_stall,
  output logic       o_ack_nack,
  output logic       o_ser_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TBIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_mode;
  logic       r_tbit;
  logic       r_hold_vld;
  logic [7:0] r_hold_data;
  logic       r_hold_mode;

  logic       w_accept;
  logic       w_pos;
  logic [7:0] w_nxt_data;
  logic       w_nxt_mode;

  function automatic logic f_tbit(input logic [7:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction

  assign o_ser_ready = i_ser_en &&
                       ((r_state == IDLE) || ((r_state == TBIT) && !r_hold_vld));
  assign w_accept    = i_ser_valid && o_ser_ready;
  // A rising-edge pulse coinciding with a falling-edge pulse is dropped.
  assign w_pos       = i_scl_pos_edge && !i_scl_neg_edge;
  // Next frame comes from the held byte, or straight from the input if it
  // is accepted in the very cycle the T-bit ends.
  assign w_nxt_data  = r_hold_vld ? r_hold_data : i_ser_data;
  assign w_nxt_mode  = r_hold_vld ? r_hold_mode : i_ser_mode;

  always_ff @(posedge i_sdr_ctrl_clk) begin
    if (i_sdr_ctrl_rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_mode      <= 1'b0;
      r_tbit      <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_data <= 8'd0;
      r_hold_mode <= 1'b0;
      o_sda       <= 1'b1;
      o_sda_oe    <= 1'b0;
      o_scl_stall <= 1'b0;
      o_ack_nack  <= 1'b1;
      o_ser_done  <= 1'b0;
    end else begin
      o_ser_done  <= 1'b0;
      o_scl_stall <= (r_state == IDLE) && i_ser_en && !i_ser_valid;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift   <= i_ser_data;
            r_mode    <= i_ser_mode;
            r_tbit    <= f_tbit(i_ser_data);
            o_sda     <= i_ser_data[7];
            o_sda_oe  <= 1'b1;
            r_bit_cnt <= 3'd7;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_scl_neg_edge) begin
            if (r_bit_cnt != 3'd0) begin
              r_bit_cnt <= r_bit_cnt - 3'd1;
              o_sda     <= r_shift[r_bit_cnt - 3'd1];
            end else if (!r_mode) begin
              o_sda   <= r_tbit;
              r_state <= TBIT;
            end else begin
              o_sda_oe <= 1'b0;
              r_state  <= ACK;
            end
          end
        end
        TBIT: begin
          if (i_scl_neg_edge) begin
            o_ser_done <= 1'b1;
            if (r_hold_vld || w_accept) begin
              r_shift    <= w_nxt_data;
              r_mode     <= w_nxt_mode;
              r_tbit     <= f_tbit(w_nxt_data);
              o_sda      <= w_nxt_data[7];
              o_sda_oe   <= 1'b1;
              r_bit_cnt  <= 3'd7;
              r_hold_vld <= 1'b0;
              r_state    <= SHIFT;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_accept) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= i_ser_data;
            r_hold_mode <= i_ser_mode;
          end
        end
        ACK: begin
          if (i_scl_neg_edge) begin
            o_ser_done <= 1'b1;
            o_sda_oe   <= 1'b0;
            r_state    <= IDLE;
          end else if (w_pos) begin
            o_ack_nack <= i_sda;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdr_tx_serializer.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sdr_tx_serializer: directed scoreboard bench for sdr_tx_serializer.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sdr_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_pos, scl_neg, ser_en, ser_mode, ser_valid, sda_in;
  logic [7:0] ser_data;
  logic       ser_ready, sda, sda_oe, scl_stall, ack_nack, ser_done;

  always #10 clk = ~clk;

  sdr_tx_serializer #(.PARITY_ODD(1)) dut (
    .i_sdr_ctrl_clk (clk),
    .i_sdr_ctrl_rst (rst),
    .i_scl_pos_edge (scl_pos),
    .i_scl_neg_edge (scl_neg),
    .i_ser_en       (ser_en),
    .i_ser_mode     (ser_mode),
    .i_ser_valid    (ser_valid),
    .i_ser_data     (ser_data),
    .o_ser_ready    (ser_ready),
    .i_sda          (sda_in),
    .o_sda          (sda),
    .o_sda_oe       (sda_oe),
    .o_scl_stall    (scl_stall),
    .o_ack_nack     (ack_nack),
    .o_ser_done     (ser_done)
  );

  // Expected line state one clock after a falling-edge pulse: {chk_sda, oe, sda}
  logic [2:0] exp_bits[$];
  logic       exp_done[$];
  int         total = 0;
  int         bad   = 0;
  logic       last_neg = 1'b0;
  logic       watch_stall = 1'b0;
  logic       stall_seen = 1'b0;
  logic       model_ack = 1'b1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT reacts to a falling edge or
  // presents a done pulse.
  always @(negedge clk) begin
    logic [2:0] e;
    if (last_neg && exp_bits.size() > 0) begin
      e = exp_bits.pop_front();
      check("sda_oe", 8'(sda_oe), 8'(e[1]));
      if (e[2]) check("sda", 8'(sda), 8'(e[0]));
    end
    if (ser_done) begin
      if (exp_done.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        check("ack_at_done", 8'(ack_nack), 8'(exp_done.pop_front()));
      end
    end
    if (watch_stall && scl_stall) stall_seen = 1'b1;
    last_neg = scl_neg;
  end

  // One clock; a handshake seen before the edge drops valid after it.
  task automatic tick();
    logic acc;
    @(negedge clk);
    acc = ser_valid && ser_ready;
    @(posedge clk);
    #1;
    if (acc) ser_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic m);
    ser_data  = d;
    ser_mode  = m;
    ser_valid = 1'b1;
    for (int n = 0; n < 64 && ser_valid; n++) tick();
    if (ser_valid) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept");
      ser_valid = 1'b0;
    end
  endtask

  task automatic neg_pulse(input logic chk, input logic oe, input logic s,
                           input logic done, input logic ack);
    exp_bits.push_back({chk, oe, s});
    if (done) exp_done.push_back(ack);
    scl_neg = 1'b1;
    tick();
    scl_neg = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic pos_pulse();
    scl_pos = 1'b1;
    tick();
    scl_pos = 1'b0;
    tick();
  endtask

  task automatic shift7(input logic [7:0] d);
    for (int k = 6; k >= 0; k--) neg_pulse(1'b1, 1'b1, d[k], 1'b0, 1'b0);
  endtask

  task automatic header_frame(input logic ack_bit);
    send_byte(8'h7E, 1'b1);
    check("hdr_accept", {6'd0, sda_oe, sda}, 8'h02);
    shift7(8'h7E);
    neg_pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sda_in = ack_bit;
    pos_pulse();
    model_ack = ack_bit;
    check("ack_sampled", 8'(ack_nack), 8'(ack_bit));
    sda_in = ~ack_bit;
    neg_pulse(1'b0, 1'b0, 1'b0, 1'b1, ack_bit);
  endtask

  initial begin
    rst = 1'b1; scl_pos = 1'b0; scl_neg = 1'b0; ser_en = 1'b0;
    ser_mode = 1'b0; ser_valid = 1'b0; ser_data = 8'h00; sda_in = 1'b1;
    tick();
    tick();
    check("reset_outs", {3'd0, sda_oe, sda, scl_stall, ack_nack, ser_done}, 8'h0A);
    check("reset_ready", 8'(ser_ready), 8'h00);

    // Stall request while idle with nothing to send
    rst = 1'b0;
    ser_en = 1'b1;
    tick();
    check("stall_idle", 8'(scl_stall), 8'h01);

    // Data frame 0xA5: bits 1,0,1,0,0,1,0,1 then T=1
    send_byte(8'hA5, 1'b0);
    check("stall_clear", 8'(scl_stall), 8'h00);
    check("a5_accept", {6'd0, sda_oe, sda}, 8'h03);
    shift7(8'hA5);
    neg_pulse(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    neg_pulse(1'b1, 1'b1, 1'b1, 1'b1, model_ack);

    // Back-to-back 0x00 then 0xFF, second accepted during the T-bit
    send_byte(8'h00, 1'b0);
    check("b2b_accept", {6'd0, sda_oe, sda}, 8'h02);
    ser_data = 8'hFF; ser_mode = 1'b0; ser_valid = 1'b1;
    stall_seen = 1'b0; watch_stall = 1'b1;
    shift7(8'h00);
    neg_pulse(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("b2b_held", 8'(ser_valid), 8'h00);
    neg_pulse(1'b1, 1'b1, 1'b1, 1'b1, model_ack);
    shift7(8'hFF);
    neg_pulse(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    watch_stall = 1'b0;
    check("b2b_no_stall", 8'(stall_seen), 8'h00);
    neg_pulse(1'b1, 1'b1, 1'b1, 1'b1, model_ack);

    // Header frames: ACK then NACK
    header_frame(1'b0);
    header_frame(1'b1);

    // Coincident edges during ACK behave as a falling edge only
    send_byte(8'h7E, 1'b1);
    shift7(8'h7E);
    neg_pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sda_in = 1'b0;
    exp_bits.push_back(3'b000);
    exp_done.push_back(model_ack);
    scl_pos = 1'b1;
    scl_neg = 1'b1;
    tick();
    scl_pos = 1'b0;
    scl_neg = 1'b0;
    check("coinc_ack", 8'(ack_nack), 8'(model_ack));
    tick();
    tick();
    sda_in = 1'b1;

    // Reset after the 4th bit of 0xC3 (line shows 0), no done pulse
    send_byte(8'hC3, 1'b0);
    shift7_partial: for (int k = 6; k >= 4; k--) begin
      neg_pulse(1'b1, 1'b1, ser_data[k], 1'b0, 1'b0);
    end
    check("c3_bit4", {6'd0, sda_oe, sda}, 8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outs", {5'd0, sda_oe, sda, ser_done}, 8'h02);
    check("midrst_idle", 8'(ser_ready), 8'h01);
    tick();
    tick();

    // Fresh byte 0x01: odd weight so T=0
    send_byte(8'h01, 1'b0);
    check("fresh_accept", {6'd0, sda_oe, sda}, 8'h02);
    shift7(8'h01);
    neg_pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    neg_pulse(1'b1, 1'b1, 1'b0, 1'b1, model_ack);

    ser_en = 1'b0;
    tick();
    tick();
    check("bits_drained", 8'(exp_bits.size()), 8'h00);
    check("done_drained", 8'(exp_done.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
